// File: rtl/sdram_device_responder.sv
// SDRAM device-side model: decodes controller commands, tracks banks and mode,
// stores write bursts in an internal RAM and returns read bursts after CAS latency.
module sdram_device_responder #(
  parameter int ADDR_WIDTH = 13,
  parameter int BANK_WIDTH = 2,
  parameter int COL_WIDTH  = 9,
  parameter int DATA_WIDTH = 16,
  parameter int DQM_WIDTH  = 2,
  parameter int MEM_AW     = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sdram_cke,
  input  logic                  sdram_cs_n,
  input  logic                  sdram_ras_n,
  input  logic                  sdram_cas_n,
  input  logic                  sdram_we_n,
  input  logic [ADDR_WIDTH-1:0] sdram_addr,
  input  logic [BANK_WIDTH-1:0] sdram_ba,
  input  logic [DQM_WIDTH-1:0]  sdram_dqm,
  input  logic [DATA_WIDTH-1:0] sdram_dq_write,
  input  logic                  sdram_dq_en,
  output logic [DATA_WIDTH-1:0] sdram_dq_read,
  output logic                  sdram_dq_oe,
  output logic [4:0]            err_flags
);

  localparam int NBANK = 1 << BANK_WIDTH;

  localparam logic [3:0] CMD_ACTIVE  = 4'b0011;
  localparam logic [3:0] CMD_READ    = 4'b0101;
  localparam logic [3:0] CMD_WRITE   = 4'b0100;
  localparam logic [3:0] CMD_PRECHG  = 4'b0010;
  localparam logic [3:0] CMD_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_LMR     = 4'b0000;
  localparam logic [3:0] CMD_BST     = 4'b0110;

  function automatic logic [COL_WIDTH-1:0] wrap_col(input logic [COL_WIDTH-1:0] base,
                                                    input logic [3:0] k,
                                                    input logic [3:0] len);
    logic [COL_WIDTH-1:0] m;
    m = COL_WIDTH'(len - 4'd1);
    return (base & ~m) | ((base + COL_WIDTH'(k)) & m);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mask_beat(input logic [DATA_WIDTH-1:0] d,
                                                      input logic [DQM_WIDTH-1:0] m);
    logic [DATA_WIDTH-1:0] r;
    r = d;
    for (int b = 0; b < DQM_WIDTH; b++)
      if (m[b]) r[b*8 +: 8] = 8'h00;
    return r;
  endfunction

  logic [3:0] cmd;
  logic       cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref, cmd_lmr, cmd_bst;

  assign cmd     = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign cmd_act = sdram_cke && (cmd == CMD_ACTIVE);
  assign cmd_rd  = sdram_cke && (cmd == CMD_READ);
  assign cmd_wr  = sdram_cke && (cmd == CMD_WRITE);
  assign cmd_pre = sdram_cke && (cmd == CMD_PRECHG);
  assign cmd_ref = sdram_cke && (cmd == CMD_REFRESH);
  assign cmd_lmr = sdram_cke && (cmd == CMD_LMR);
  assign cmd_bst = sdram_cke && (cmd == CMD_BST);

  logic [NBANK-1:0]      bank_open;
  logic [ADDR_WIDTH-1:0] bank_row [NBANK];
  logic [3:0]            burst_len;
  logic                  cas3;

  logic                  bst_active, bst_write, bst_ap, bst_cl3;
  logic [3:0]            bst_k, bst_len;
  logic [COL_WIDTH-1:0]  bst_col;
  logic [BANK_WIDTH-1:0] bst_bank;
  logic [ADDR_WIDTH-1:0] bst_row;

  logic                  beat_go, beat_write, beat_ap, beat_cl3, beat_last, rd_beat;
  logic [3:0]            beat_k, beat_len;
  logic [COL_WIDTH-1:0]  beat_base, beat_col;
  logic [BANK_WIDTH-1:0] beat_bank;
  logic [ADDR_WIDTH-1:0] beat_row;
  logic [MEM_AW-1:0]     mem_idx;

  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] data_p0, data_p1, data_p2;
  logic                  vld_p0, vld_p1, vld_p2;
  logic [DQM_WIDTH-1:0]  dqm_d1, dqm_d2;

  // A new READ/WRITE supplies beat 0 itself; otherwise an open burst supplies the next beat.
  always_comb begin
    beat_go    = 1'b0;
    beat_write = bst_write;
    beat_ap    = bst_ap;
    beat_cl3   = bst_cl3;
    beat_base  = bst_col;
    beat_k     = bst_k;
    beat_len   = bst_len;
    beat_bank  = bst_bank;
    beat_row   = bst_row;
    if (cmd_rd || cmd_wr) begin
      beat_go    = 1'b1;
      beat_write = cmd_wr;
      beat_ap    = sdram_addr[10];
      beat_cl3   = cas3;
      beat_base  = sdram_addr[COL_WIDTH-1:0];
      beat_k     = 4'd0;
      beat_len   = burst_len;
      beat_bank  = sdram_ba;
      beat_row   = bank_open[sdram_ba] ? bank_row[sdram_ba] : '0;
    end else if (sdram_cke && bst_active && !cmd_bst) begin
      beat_go = 1'b1;
    end
  end

  assign beat_last = (beat_k == beat_len - 4'd1);
  assign beat_col  = wrap_col(beat_base, beat_k, beat_len);
  assign mem_idx   = MEM_AW'({beat_bank, beat_row, beat_col});
  assign rd_beat   = beat_go && !beat_write;
  // Read data is fetched when the beat issues, so a WRITE landing on the
  // return cycle never competes with it for the array.
  assign rd_word   = mem[mem_idx];

  always_ff @(posedge clk) begin
    if (!reset && beat_go && beat_write)
      for (int b = 0; b < DQM_WIDTH; b++)
        if (!sdram_dqm[b]) mem[mem_idx][b*8 +: 8] <= sdram_dq_write[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (sdram_cke) begin
      data_p0 <= rd_word;
      data_p1 <= vld_p0 ? data_p0 : rd_word;
      data_p2 <= data_p1;
      dqm_d1  <= sdram_dqm;
      dqm_d2  <= dqm_d1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_open     <= '0;
      burst_len     <= 4'd1;
      cas3          <= 1'b0;
      bst_active    <= 1'b0;
      vld_p0        <= 1'b0;
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      sdram_dq_oe   <= 1'b0;
      sdram_dq_read <= '0;
      err_flags     <= '0;
    end else begin
      if (beat_go) begin
        if (beat_write && !sdram_dq_en) err_flags[4] <= 1'b1;
        if (beat_last) begin
          bst_active <= 1'b0;
          if (beat_ap) bank_open[beat_bank] <= 1'b0;
        end else begin
          bst_active <= 1'b1;
          bst_k      <= beat_k + 4'd1;
        end
      end else if (cmd_bst) begin
        bst_active <= 1'b0;
      end

      if (cmd_rd || cmd_wr) begin
        bst_write <= beat_write;
        bst_ap    <= beat_ap;
        bst_cl3   <= beat_cl3;
        bst_col   <= beat_base;
        bst_len   <= beat_len;
        bst_bank  <= beat_bank;
        bst_row   <= beat_row;
        if (!bank_open[sdram_ba]) err_flags[0] <= 1'b1;
      end

      if (cmd_act) begin
        if (bank_open[sdram_ba]) err_flags[1] <= 1'b1;
        bank_open[sdram_ba] <= 1'b1;
        bank_row[sdram_ba]  <= sdram_addr;
      end

      if (cmd_pre) begin
        if (sdram_addr[10]) bank_open <= '0;
        else                bank_open[sdram_ba] <= 1'b0;
      end

      if (cmd_ref && (|bank_open)) err_flags[3] <= 1'b1;

      if (cmd_lmr) begin
        case (sdram_addr[2:0])
          3'b000:  burst_len <= 4'd1;
          3'b001:  burst_len <= 4'd2;
          3'b010:  burst_len <= 4'd4;
          3'b011:  burst_len <= 4'd8;
          default: begin
            burst_len    <= 4'd1;
            err_flags[2] <= 1'b1;
          end
        endcase
        case (sdram_addr[6:4])
          3'd2:    cas3 <= 1'b0;
          3'd3:    cas3 <= 1'b1;
          default: begin
            cas3         <= 1'b1;
            err_flags[2] <= 1'b1;
          end
        endcase
      end

      // CL3 beats enter at p0, CL2 beats skip to p1; all leave through p2 and the output register.
      if (sdram_cke) begin
        vld_p0        <= rd_beat && beat_cl3;
        vld_p1        <= vld_p0 || (rd_beat && !beat_cl3);
        vld_p2        <= vld_p1;
        sdram_dq_oe   <= vld_p2;
        sdram_dq_read <= vld_p2 ? mask_beat(data_p2, dqm_d2) : '0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_device_responder.sv
// Directed bench for sdram_device_responder: mode, bursts, masking, cke hold,
// error flags and mid-burst reset, each against hand-computed expectations.
module tb_sdram_device_responder;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;
  localparam logic [3:0] BST = 4'b0110;

  logic        clk = 1'b0;
  logic        reset, cke, cs_n, ras_n, cas_n, we_n, dq_en;
  logic [12:0] addr;
  logic [1:0]  ba, dqm;
  logic [15:0] dq_write, dq_read;
  logic        dq_oe;
  logic [4:0]  err_flags;

  int checks = 0;
  int failures = 0;

  sdram_device_responder dut (
    .clk            (clk),
    .reset          (reset),
    .sdram_cke      (cke),
    .sdram_cs_n     (cs_n),
    .sdram_ras_n    (ras_n),
    .sdram_cas_n    (cas_n),
    .sdram_we_n     (we_n),
    .sdram_addr     (addr),
    .sdram_ba       (ba),
    .sdram_dqm      (dqm),
    .sdram_dq_write (dq_write),
    .sdram_dq_en    (dq_en),
    .sdram_dq_read  (dq_read),
    .sdram_dq_oe    (dq_oe),
    .err_flags      (err_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one command for one rising edge, then return 1ns after that edge.
  task automatic step(input logic [3:0] c, input logic [12:0] a, input logic [1:0] b,
                      input logic [15:0] d, input logic [1:0] m, input logic en);
    {cs_n, ras_n, cas_n, we_n} = c;
    addr = a; ba = b; dq_write = d; dqm = m; dq_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    step(NOP, 13'd0, 2'd0, 16'h0000, 2'b00, 1'b0);
  endtask

  logic [15:0] exp2 [4];
  int          beats;

  initial begin
    exp2[0] = 16'h0033; exp2[1] = 16'h0044; exp2[2] = 16'h0011; exp2[3] = 16'h0022;
    reset = 1'b1; cke = 1'b1;
    nop(); nop();
    chk("rst_oe", {31'd0, dq_oe}, 32'd0);
    chk("rst_dq", {16'd0, dq_read}, 32'd0);
    chk("rst_err", {27'd0, err_flags}, 32'd0);
    reset = 1'b0;

    // CL2 BL1 single write/read
    step(LMR, 13'h020, 2'd0, 16'h0, 2'b00, 1'b0);
    step(ACT, 13'd5, 2'd0, 16'h0, 2'b00, 1'b0);
    step(WR, 13'd3, 2'd0, 16'hBEEF, 2'b00, 1'b1);
    step(RD, 13'd3, 2'd0, 16'h0, 2'b00, 1'b0);
    chk("t1_oe_t0", {31'd0, dq_oe}, 32'd0);
    nop(); chk("t1_oe_t1", {31'd0, dq_oe}, 32'd0);
    nop(); chk("t1_oe_t2", {31'd0, dq_oe}, 32'd1);
    chk("t1_dq_t2", {16'd0, dq_read}, 32'h0000BEEF);
    nop(); chk("t1_oe_t3", {31'd0, dq_oe}, 32'd0);
    chk("t1_err", {27'd0, err_flags}, 32'd0);

    // CL3 BL4 with wrap inside the aligned block
    step(LMR, 13'h032, 2'd0, 16'h0, 2'b00, 1'b0);
    step(WR, 13'd4, 2'd0, 16'h0011, 2'b00, 1'b1);
    step(NOP, 13'd0, 2'd0, 16'h0022, 2'b00, 1'b1);
    step(NOP, 13'd0, 2'd0, 16'h0033, 2'b00, 1'b1);
    step(NOP, 13'd0, 2'd0, 16'h0044, 2'b00, 1'b1);
    step(RD, 13'd6, 2'd0, 16'h0, 2'b00, 1'b0);
    chk("t2_oe_t0", {31'd0, dq_oe}, 32'd0);
    nop(); chk("t2_oe_t1", {31'd0, dq_oe}, 32'd0);
    nop(); chk("t2_oe_t2", {31'd0, dq_oe}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      nop();
      chk($sformatf("t2_oe_b%0d", i), {31'd0, dq_oe}, 32'd1);
      chk($sformatf("t2_dq_b%0d", i), {16'd0, dq_read}, {16'd0, exp2[i]});
    end
    nop(); chk("t2_oe_end", {31'd0, dq_oe}, 32'd0);

    // Write byte mask, then read byte mask
    step(LMR, 13'h020, 2'd0, 16'h0, 2'b00, 1'b0);
    step(WR, 13'd10, 2'd0, 16'hAAAA, 2'b00, 1'b1);
    step(WR, 13'd10, 2'd0, 16'h5555, 2'b10, 1'b1);
    step(RD, 13'd10, 2'd0, 16'h0, 2'b00, 1'b0);
    nop(); nop();
    chk("t3_wmask", {16'd0, dq_read}, 32'h0000AA55);
    step(RD, 13'd10, 2'd0, 16'h0, 2'b01, 1'b0);
    nop(); nop();
    chk("t3_rmask_oe", {31'd0, dq_oe}, 32'd1);
    chk("t3_rmask", {16'd0, dq_read}, 32'h0000AA00);

    // cke low for one cycle stretches the read latency by one
    step(RD, 13'd3, 2'd0, 16'h0, 2'b00, 1'b0);
    cke = 1'b0; nop(); cke = 1'b1;
    chk("cke_oe_t1", {31'd0, dq_oe}, 32'd0);
    nop(); chk("cke_oe_t2", {31'd0, dq_oe}, 32'd0);
    nop(); chk("cke_oe_t3", {31'd0, dq_oe}, 32'd1);
    chk("cke_dq_t3", {16'd0, dq_read}, 32'h0000BEEF);
    nop();

    // BL8 read terminated two cycles after issue
    step(LMR, 13'h023, 2'd0, 16'h0, 2'b00, 1'b0);
    beats = 0;
    step(RD, 13'd0, 2'd0, 16'h0, 2'b00, 1'b0);
    if (dq_oe) beats++;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) step(BST, 13'd0, 2'd0, 16'h0, 2'b00, 1'b0);
      else        nop();
      if (dq_oe) beats++;
    end
    chk("t5_beats", beats, 32'd2);

    // Sticky error flags
    step(LMR, 13'h020, 2'd0, 16'h0, 2'b00, 1'b0);
    step(RD, 13'd0, 2'd1, 16'h0, 2'b00, 1'b0);
    chk("t4_idle", {27'd0, err_flags}, 32'h01);
    nop(); nop(); nop();
    step(ACT, 13'd7, 2'd0, 16'h0, 2'b00, 1'b0);
    chk("t4_reopen", {27'd0, err_flags}, 32'h03);
    step(REF, 13'd0, 2'd0, 16'h0, 2'b00, 1'b0);
    chk("t4_refresh", {27'd0, err_flags}, 32'h0B);
    step(LMR, 13'h074, 2'd0, 16'h0, 2'b00, 1'b0);
    chk("t4_mode", {27'd0, err_flags}, 32'h0F);
    step(LMR, 13'h020, 2'd0, 16'h0, 2'b00, 1'b0);
    step(WR, 13'd3, 2'd0, 16'h1234, 2'b00, 1'b0);
    chk("t4_dqen", {27'd0, err_flags}, 32'h1F);

    // Reset in the middle of a BL8 read burst
    step(LMR, 13'h023, 2'd0, 16'h0, 2'b00, 1'b0);
    step(RD, 13'd0, 2'd0, 16'h0, 2'b00, 1'b0);
    nop(); nop();
    chk("t6_oe_pre", {31'd0, dq_oe}, 32'd1);
    reset = 1'b1; nop();
    chk("t6_oe_rst", {31'd0, dq_oe}, 32'd0);
    chk("t6_err_rst", {27'd0, err_flags}, 32'd0);
    reset = 1'b0;
    step(RD, 13'd3, 2'd0, 16'h0, 2'b00, 1'b0);
    chk("t6_idle", {27'd0, err_flags}, 32'h01);
    nop(); chk("t6_oe_t1", {31'd0, dq_oe}, 32'd0);
    nop(); chk("t6_oe_t2", {31'd0, dq_oe}, 32'd1);
    nop(); chk("t6_oe_t3", {31'd0, dq_oe}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
